// File: rtl/csr_pkg.sv
// Shared constants and types for the SYSTEM-opcode / trap sequencer.
// Valid handshake: start/ext_trap are sampled only in IDLE; done is a one-cycle pulse.
package csr_pkg;

  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_PRIV   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_RSVD   = 3'b100;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [11:0] F12_ECALL  = 12'h000;
  localparam logic [11:0] F12_EBREAK = 12'h001;
  localparam logic [11:0] F12_MRET   = 12'h302;
  localparam logic [11:0] F12_WFI    = 12'h105;

  localparam logic [4:0] CAUSE_ILLEGAL    = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT = 5'd3;
  localparam logic [4:0] CAUSE_ECALL_M    = 5'd11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_READ, ST_WRITE, ST_TRAP, ST_RET_RD, ST_RET, ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    SYS_CSR_OP, SYS_ECALL, SYS_EBREAK, SYS_MRET, SYS_WFI, SYS_ILLEGAL
  } sys_class_e;

endpackage

// File: rtl/sys_decode.sv
// Combinational classifier for a SYSTEM-opcode instruction word.
module sys_decode
  import csr_pkg::*;
(
  input  logic [31:0] instr,
  output sys_class_e  sys_class,
  output logic        write_may_occur,
  output logic        use_imm
);

  logic [2:0]  funct3;
  logic [4:0]  rs1_field;
  logic [4:0]  rd_field;
  logic [11:0] funct12;

  assign funct3    = instr[14:12];
  assign rs1_field = instr[19:15];
  assign rd_field  = instr[11:7];
  assign funct12   = instr[31:20];

  always_comb begin
    sys_class       = SYS_ILLEGAL;
    write_may_occur = 1'b0;
    use_imm         = funct3[2];
    if (instr[6:0] == OPC_SYSTEM) begin
      if (funct3 == F3_PRIV) begin
        if (rs1_field == 5'd0 && rd_field == 5'd0) begin
          case (funct12)
            F12_ECALL:  sys_class = SYS_ECALL;
            F12_EBREAK: sys_class = SYS_EBREAK;
            F12_MRET:   sys_class = SYS_MRET;
            F12_WFI:    sys_class = SYS_WFI;
            default:    sys_class = SYS_ILLEGAL;
          endcase
        end
      end else if (funct3 != F3_RSVD) begin
        sys_class = SYS_CSR_OP;
        // Set/clear forms with a zero source leave the CSR untouched.
        write_may_occur = (funct3[1:0] == 2'b01) || (rs1_field != 5'd0);
      end
    end
  end

endmodule

// File: rtl/csr_sequencer.sv
// Multicycle sequencer driving the CSR file for SYSTEM instructions and traps.
// Outputs are a Moore decode of state plus latched fields.
module csr_sequencer
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_ADDR    = 32'h0000_0004,
  parameter logic [4:0]  ILLEGAL_CAUSE = 5'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic        ext_trap,
  input  logic [4:0]  ext_cause,
  input  logic [31:0] ext_tval,
  output logic        busy,
  output logic        done,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [31:0] next_pc,
  output logic        trap_taken,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_bus,
  output logic [31:0] csr_fault_addr,
  output logic        csr_read,
  output logic        csr_write,
  output logic        csr_trap,
  output logic        csr_ret,
  output logic [1:0]  csr_write_type,
  output logic [4:0]  csr_trap_cause,
  input  logic [31:0] csr_rdata,
  input  logic        csr_invalid,
  output state_e      state_dbg
);

  state_e      state, state_next;
  logic [31:0] instr_q, pc_q, rs1_q, tval_q, old_q, mepc_q;
  logic [4:0]  cause_q;
  logic        ext_q, trap_q, ret_q;

  sys_class_e  dec_class;
  logic        dec_write, dec_imm;
  logic [4:0]  dec_cause;
  logic [11:0] op_csr;

  assign op_csr = instr_q[31:20];

  sys_decode u_decode (
    .instr           (instr_q),
    .sys_class       (dec_class),
    .write_may_occur (dec_write),
    .use_imm         (dec_imm)
  );

  always_comb begin
    dec_cause = ILLEGAL_CAUSE;
    case (dec_class)
      SYS_ECALL:  dec_cause = CAUSE_ECALL_M;
      SYS_EBREAK: dec_cause = CAUSE_BREAKPOINT;
      default:    dec_cause = ILLEGAL_CAUSE;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (ext_trap)   state_next = ST_TRAP;
        else if (start) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        case (dec_class)
          SYS_CSR_OP: state_next = ST_READ;
          SYS_MRET:   state_next = ST_RET_RD;
          SYS_WFI:    state_next = ST_DONE;
          default:    state_next = ST_TRAP;
        endcase
      end
      ST_READ: begin
        // Writing a read-only CSR (addr[11:10] == 2'b11) is illegal.
        if (csr_invalid)                            state_next = ST_TRAP;
        else if (dec_write && op_csr[11:10] == 2'b11) state_next = ST_TRAP;
        else if (dec_write)                         state_next = ST_WRITE;
        else                                        state_next = ST_DONE;
      end
      ST_WRITE:  state_next = ST_DONE;
      ST_TRAP:   state_next = ST_DONE;
      ST_RET_RD: state_next = ST_RET;
      ST_RET:    state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      rs1_q   <= '0;
      tval_q  <= '0;
      old_q   <= '0;
      mepc_q  <= '0;
      cause_q <= '0;
      ext_q   <= 1'b0;
      trap_q  <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ext_trap) begin
            pc_q    <= pc;
            cause_q <= ext_cause;
            tval_q  <= ext_tval;
            ext_q   <= 1'b1;
            trap_q  <= 1'b0;
            ret_q   <= 1'b0;
          end else if (start) begin
            instr_q <= instr;
            pc_q    <= pc;
            rs1_q   <= rs1_val;
            ext_q   <= 1'b0;
            trap_q  <= 1'b0;
            ret_q   <= 1'b0;
          end
        end
        ST_DECODE: cause_q <= dec_cause;
        ST_READ: begin
          // Only an illegal trap can follow READ, so the cause is preset here.
          cause_q <= ILLEGAL_CAUSE;
          if (!csr_invalid) old_q <= csr_rdata;
        end
        ST_TRAP:   trap_q <= 1'b1;
        ST_RET_RD: mepc_q <= csr_rdata;
        ST_RET:    ret_q  <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy           = (state != ST_IDLE);
    done           = 1'b0;
    rd_we          = 1'b0;
    rd_addr        = '0;
    rd_data        = '0;
    next_pc        = '0;
    trap_taken     = 1'b0;
    csr_addr       = '0;
    csr_bus        = '0;
    csr_fault_addr = '0;
    csr_read       = 1'b0;
    csr_write      = 1'b0;
    csr_trap       = 1'b0;
    csr_ret        = 1'b0;
    csr_write_type = '0;
    csr_trap_cause = '0;
    case (state)
      ST_READ: begin
        csr_read = 1'b1;
        csr_addr = op_csr;
      end
      ST_WRITE: begin
        csr_write      = 1'b1;
        csr_addr       = op_csr;
        csr_write_type = instr_q[13:12];
        csr_bus        = dec_imm ? {27'b0, instr_q[19:15]} : rs1_q;
      end
      ST_TRAP: begin
        csr_trap       = 1'b1;
        csr_trap_cause = cause_q;
        csr_bus        = pc_q;
        csr_fault_addr = ext_q ? tval_q : 32'd0;
      end
      ST_RET_RD: begin
        csr_read = 1'b1;
        csr_addr = CSR_MEPC;
      end
      ST_RET: csr_ret = 1'b1;
      ST_DONE: begin
        done       = 1'b1;
        trap_taken = trap_q;
        if (trap_q)     next_pc = MTVEC_ADDR;
        else if (ret_q) next_pc = mepc_q;
        else            next_pc = pc_q + 32'd4;
        // trap_q also masks the stale instr_q left behind by an external trap.
        rd_we   = !trap_q && (dec_class == SYS_CSR_OP) && (instr_q[11:7] != 5'd0);
        rd_addr = instr_q[11:7];
        rd_data = old_q;
      end
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_csr_sequencer.sv
// Self-checking bench for csr_sequencer: directed scenarios plus randomized
// instructions scored against a cycle-count reference model of the sequencer.
module tb_csr_sequencer;
  import csr_pkg::*;

  localparam logic [31:0] MTVEC = 32'h0000_0004;

  typedef struct packed {
    logic [7:0]  done_cyc;
    logic [31:0] next_pc;
    logic        trap_taken;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  rd_cyc;
    logic [11:0] rd_csr;
    logic        wr_seen;
    logic [7:0]  wr_cyc;
    logic [11:0] wr_addr;
    logic [1:0]  wr_type;
    logic [31:0] wr_bus;
    logic        trap_seen;
    logic [4:0]  trap_cause;
    logic [31:0] trap_bus;
    logic [31:0] trap_fault;
    logic        ret_seen;
    logic        busy_ok;
    logic        idle_after;
  } res_t;

  logic        clk, rst_n, start, ext_trap;
  logic [31:0] pc, instr, rs1_val, ext_tval;
  logic [4:0]  ext_cause;
  logic        busy, done, rd_we, trap_taken;
  logic [4:0]  rd_addr, csr_trap_cause;
  logic [31:0] rd_data, next_pc, csr_bus, csr_fault_addr, csr_rdata;
  logic [11:0] csr_addr;
  logic        csr_read, csr_write, csr_trap, csr_ret, csr_invalid;
  logic [1:0]  csr_write_type;
  state_e      state_dbg;

  logic [31:0] csr_val [4096];
  bit          csr_ok  [4096];
  logic [$bits(res_t)-1:0] exp_q [$];
  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Behavioural CSR file: fixed contents, invalid outside the implemented set.
  assign csr_rdata   = csr_val[csr_addr];
  assign csr_invalid = csr_read & ~csr_ok[csr_addr];

  csr_sequencer #(.MTVEC_ADDR(MTVEC), .ILLEGAL_CAUSE(5'd2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .instr(instr), .rs1_val(rs1_val),
    .ext_trap(ext_trap), .ext_cause(ext_cause), .ext_tval(ext_tval),
    .busy(busy), .done(done), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .next_pc(next_pc), .trap_taken(trap_taken), .csr_addr(csr_addr), .csr_bus(csr_bus),
    .csr_fault_addr(csr_fault_addr), .csr_read(csr_read), .csr_write(csr_write),
    .csr_trap(csr_trap), .csr_ret(csr_ret), .csr_write_type(csr_write_type),
    .csr_trap_cause(csr_trap_cause), .csr_rdata(csr_rdata), .csr_invalid(csr_invalid),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [11:0] csr, input logic [4:0] rs1f,
                                      input logic [2:0] f3, input logic [4:0] rdf);
    return {csr, rs1f, f3, rdf, 7'b1110011};
  endfunction

  function automatic res_t set_trap(input res_t e, input logic [4:0] cause,
                                    input logic [7:0] cyc, input logic [31:0] bus);
    res_t r = e;
    r.trap_seen  = 1'b1;
    r.trap_cause = cause;
    r.trap_bus   = bus;
    r.done_cyc   = cyc;
    r.next_pc    = MTVEC;
    r.trap_taken = 1'b1;
    return r;
  endfunction

  // ---------------- reference model ----------------
  function automatic res_t model(input logic [31:0] i_instr, i_pc, i_rs1, input bit i_ext,
                                 input logic [4:0] i_cause, input logic [31:0] i_tval);
    res_t e;
    logic [2:0] f3;
    logic [4:0] rdf, rsf;
    logic [11:0] f12;
    bit writes;
    e = '0;
    e.busy_ok = 1'b1;
    e.idle_after = 1'b1;
    f3 = i_instr[14:12]; rdf = i_instr[11:7]; rsf = i_instr[19:15]; f12 = i_instr[31:20];
    if (i_ext) begin
      e = set_trap(e, i_cause, 8'd2, i_pc);
      e.trap_fault = i_tval;
      return e;
    end
    e.next_pc = i_pc + 32'd4;
    if (i_instr[6:0] != 7'b1110011 || f3 == 3'd4 ||
        (f3 == 3'd0 && (rsf != 0 || rdf != 0 || !(f12 inside {12'h000, 12'h001, 12'h302, 12'h105})))) begin
      e = set_trap(e, 5'd2, 8'd3, i_pc);
    end else if (f3 == 3'd0) begin
      if (f12 == 12'h000) e = set_trap(e, 5'd11, 8'd3, i_pc);
      else if (f12 == 12'h001) e = set_trap(e, 5'd3, 8'd3, i_pc);
      else if (f12 == 12'h302) begin
        e.rd_cyc = 8'd2; e.rd_csr = 12'h341; e.ret_seen = 1'b1;
        e.next_pc = csr_val[12'h341]; e.done_cyc = 8'd4;
      end else e.done_cyc = 8'd2;
    end else begin
      e.rd_cyc = 8'd2;
      e.rd_csr = f12;
      writes = (f3[1:0] == 2'b01) || (rsf != 0);
      if (!csr_ok[f12] || (writes && f12[11:10] == 2'b11)) e = set_trap(e, 5'd2, 8'd4, i_pc);
      else begin
        if (rdf != 0) begin e.rd_we = 1'b1; e.rd_addr = rdf; e.rd_data = csr_val[f12]; end
        if (writes) begin
          e.wr_seen = 1'b1; e.wr_cyc = 8'd3; e.wr_addr = f12; e.wr_type = f3[1:0];
          e.wr_bus = f3[2] ? {27'b0, rsf} : i_rs1;
          e.done_cyc = 8'd4;
        end else e.done_cyc = 8'd3;
      end
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  // Entered #1 after a rising edge with the DUT idle; cycle 1 is the cycle after the start edge.
  task automatic drive_op(input logic [31:0] i_instr, i_pc, i_rs1, input bit i_ext,
                          input logic [4:0] i_cause, input logic [31:0] i_tval,
                          input bit i_start, input bit i_glitch, output res_t o);
    bit fin = 0;
    o = '0;
    o.busy_ok = 1'b1;
    instr = i_instr; pc = i_pc; rs1_val = i_rs1;
    ext_trap = i_ext; ext_cause = i_cause; ext_tval = i_tval; start = i_start;
    @(posedge clk); #1;
    start = 1'b0; ext_trap = 1'b0;
    for (int c = 1; c <= 20 && !fin; c++) begin
      if (!busy) o.busy_ok = 1'b0;
      if (csr_read && o.rd_cyc == 0) begin o.rd_cyc = 8'(c); o.rd_csr = csr_addr; end
      if (csr_write) begin
        o.wr_seen = 1'b1; o.wr_cyc = 8'(c); o.wr_addr = csr_addr;
        o.wr_type = csr_write_type; o.wr_bus = csr_bus;
      end
      if (csr_trap) begin
        o.trap_seen = 1'b1; o.trap_cause = csr_trap_cause;
        o.trap_bus = csr_bus; o.trap_fault = csr_fault_addr;
      end
      if (csr_ret) o.ret_seen = 1'b1;
      if (i_glitch && c == 2) begin start = 1'b1; ext_trap = 1'b1; instr = 32'h0000_0073; end
      if (i_glitch && c == 3) begin start = 1'b0; ext_trap = 1'b0; instr = i_instr; end
      if (done) begin
        fin = 1;
        o.done_cyc = 8'(c); o.next_pc = next_pc; o.trap_taken = trap_taken; o.rd_we = rd_we;
        if (rd_we) begin o.rd_addr = rd_addr; o.rd_data = rd_data; end
      end else begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0; ext_trap = 1'b0;
    if (fin) begin
      @(posedge clk); #1;
      o.idle_after = !busy && !done;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    res_t o, e;
    rst_n = 1'b0; start = 0; ext_trap = 0; pc = 0; instr = 0; rs1_val = 0; ext_cause = 0; ext_tval = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if ({busy, done, rd_we, rd_addr, rd_data, next_pc, trap_taken, csr_addr, csr_bus, csr_fault_addr,
         csr_read, csr_write, csr_trap, csr_ret, csr_write_type, csr_trap_cause} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b read=%b write=%b trap=%b ret=%b, all must be 0",
               busy, done, csr_read, csr_write, csr_trap, csr_ret);
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if (busy !== 1'b0 || state_dbg !== ST_IDLE)
      $display("FAIL reset_idle: got busy=%b state=%0d exp busy=0 state=IDLE", busy, state_dbg);
    else pass_cnt++;
    // Asynchronous reset while the WRITE strobe is up.
    instr = enc(12'h340, 5'd6, 3'b001, 5'd5); pc = 32'h40; rs1_val = 32'h1111_2222; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_cnt++;
    if (csr_write !== 1'b1) $display("FAIL reset_pre_write: got csr_write=%b exp 1", csr_write);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (busy !== 1'b0 || csr_write !== 1'b0 || done !== 1'b0 || state_dbg !== ST_IDLE)
      $display("FAIL reset_mid_write: got busy=%b csr_write=%b done=%b exp 0/0/0", busy, csr_write, done);
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(model(enc(12'h340, 5'd6, 3'b001, 5'd5), 32'h44, 32'h3333_4444, 0, 5'd0, 32'd0));
    drive_op(enc(12'h340, 5'd6, 3'b001, 5'd5), 32'h44, 32'h3333_4444, 0, 5'd0, 32'd0, 1, 0, o);
    e = exp_q.pop_front();
    chk_cnt++;
    if (o !== e) $display("FAIL reset_recover: got %h exp %h", o, e);
    else pass_cnt++;
  endtask

  task automatic test_csr_write;
    res_t o, e;
    csr_val[12'h340] = 32'h1234_5678;
    exp_q.push_back(model(enc(12'h340, 5'd7, 3'b001, 5'd5), 32'h80, 32'hDEAD_BEEF, 0, 5'd0, 32'd0));
    drive_op(enc(12'h340, 5'd7, 3'b001, 5'd5), 32'h80, 32'hDEAD_BEEF, 0, 5'd0, 32'd0, 1, 0, o);
    e = exp_q.pop_front();
    chk_cnt++;
    if (o !== e) $display("FAIL csrrw_model: got %h exp %h", o, e); else pass_cnt++;
    chk_cnt++;
    if (o.rd_cyc !== 8'd2 || o.wr_cyc !== 8'd3 || o.done_cyc !== 8'd4)
      $display("FAIL csrrw_timing: got read=%0d write=%0d done=%0d exp 2/3/4", o.rd_cyc, o.wr_cyc, o.done_cyc);
    else pass_cnt++;
    chk_cnt++;
    if (o.wr_type !== 2'b01 || o.wr_bus !== 32'hDEAD_BEEF)
      $display("FAIL csrrw_bus: got type=%b bus=%h exp 01/deadbeef", o.wr_type, o.wr_bus);
    else pass_cnt++;
    chk_cnt++;
    if (o.rd_we !== 1'b1 || o.rd_addr !== 5'd5 || o.rd_data !== 32'h1234_5678 || o.next_pc !== 32'h84)
      $display("FAIL csrrw_wb: got we=%b rd=%0d data=%h npc=%h exp 1/5/12345678/84",
               o.rd_we, o.rd_addr, o.rd_data, o.next_pc);
    else pass_cnt++;
  endtask

  task automatic test_no_write;
    res_t o, e;
    csr_val[12'h300] = 32'h0000_1888;
    exp_q.push_back(model(enc(12'h300, 5'd0, 3'b010, 5'd1), 32'h90, 32'hFFFF_FFFF, 0, 5'd0, 32'd0));
    drive_op(enc(12'h300, 5'd0, 3'b010, 5'd1), 32'h90, 32'hFFFF_FFFF, 0, 5'd0, 32'd0, 1, 0, o);
    e = exp_q.pop_front();
    chk_cnt++;
    if (o !== e) $display("FAIL csrrs_x0_model: got %h exp %h", o, e); else pass_cnt++;
    chk_cnt++;
    if (o.wr_seen !== 1'b0 || o.done_cyc !== 8'd3 || o.rd_data !== 32'h0000_1888)
      $display("FAIL csrrs_x0: got write=%b done=%0d data=%h exp 0/3/00001888", o.wr_seen, o.done_cyc, o.rd_data);
    else pass_cnt++;
    drive_op(enc(12'h300, 5'd0, 3'b111, 5'd3), 32'h94, 32'd0, 0, 5'd0, 32'd0, 1, 0, o);
    chk_cnt++;
    if (o.wr_seen !== 1'b0 || o.done_cyc !== 8'd3 || o.rd_addr !== 5'd3)
      $display("FAIL csrrci_zero: got write=%b done=%0d rd=%0d exp 0/3/3", o.wr_seen, o.done_cyc, o.rd_addr);
    else pass_cnt++;
    drive_op(enc(12'hF11, 5'd1, 3'b110, 5'd2), 32'h98, 32'd0, 0, 5'd0, 32'd0, 1, 0, o);
    chk_cnt++;
    if (o.trap_cause !== 5'd2 || o.trap_taken !== 1'b1 || o.wr_seen !== 1'b0 || o.rd_we !== 1'b0)
      $display("FAIL csrrsi_readonly: got cause=%0d taken=%b write=%b we=%b exp 2/1/0/0",
               o.trap_cause, o.trap_taken, o.wr_seen, o.rd_we);
    else pass_cnt++;
  endtask

  task automatic test_invalid_csr;
    res_t o;
    drive_op(enc(12'h7C0, 5'd1, 3'b001, 5'd5), 32'h100, 32'h5, 0, 5'd0, 32'd0, 1, 0, o);
    chk_cnt++;
    if (o.trap_cause !== 5'd2 || o.trap_bus !== 32'h100 || o.next_pc !== 32'h4 ||
        o.trap_taken !== 1'b1 || o.rd_we !== 1'b0 || o.done_cyc !== 8'd4)
      $display("FAIL invalid_csr: got cause=%0d bus=%h npc=%h taken=%b we=%b done=%0d exp 2/100/4/1/0/4",
               o.trap_cause, o.trap_bus, o.next_pc, o.trap_taken, o.rd_we, o.done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_ecall_mret;
    res_t o;
    drive_op(32'h0000_0073, 32'h200, 32'd0, 0, 5'd0, 32'd0, 1, 0, o);
    chk_cnt++;
    if (o.trap_cause !== 5'd11 || o.trap_bus !== 32'h200 || o.next_pc !== 32'h4 || o.done_cyc !== 8'd3)
      $display("FAIL ecall: got cause=%0d bus=%h npc=%h done=%0d exp 11/200/4/3",
               o.trap_cause, o.trap_bus, o.next_pc, o.done_cyc);
    else pass_cnt++;
    drive_op(32'h0010_0073, 32'h208, 32'd0, 0, 5'd0, 32'd0, 1, 0, o);
    chk_cnt++;
    if (o.trap_cause !== 5'd3 || o.trap_fault !== 32'd0)
      $display("FAIL ebreak: got cause=%0d fault=%h exp 3/0", o.trap_cause, o.trap_fault);
    else pass_cnt++;
    csr_val[12'h341] = 32'h204;
    drive_op(32'h3020_0073, 32'h300, 32'd0, 0, 5'd0, 32'd0, 1, 0, o);
    chk_cnt++;
    if (o.rd_csr !== 12'h341 || o.ret_seen !== 1'b1 || o.next_pc !== 32'h204 ||
        o.done_cyc !== 8'd4 || o.trap_taken !== 1'b0)
      $display("FAIL mret: got addr=%h ret=%b npc=%h done=%0d taken=%b exp 341/1/204/4/0",
               o.rd_csr, o.ret_seen, o.next_pc, o.done_cyc, o.trap_taken);
    else pass_cnt++;
    drive_op(32'h1050_0073, 32'hFFFF_FFFC, 32'd0, 0, 5'd0, 32'd0, 1, 0, o);
    chk_cnt++;
    if (o.next_pc !== 32'h0 || o.trap_taken !== 1'b0 || o.rd_we !== 1'b0)
      $display("FAIL wfi_wrap: got npc=%h taken=%b we=%b exp 0/0/0", o.next_pc, o.trap_taken, o.rd_we);
    else pass_cnt++;
  endtask

  task automatic test_ext_trap;
    res_t o;
    drive_op(enc(12'h340, 5'd7, 3'b001, 5'd5), 32'h400, 32'h1, 1, 5'd4, 32'h1003, 1, 0, o);
    chk_cnt++;
    if (o.trap_fault !== 32'h1003 || o.trap_cause !== 5'd4 || o.trap_bus !== 32'h400 ||
        o.done_cyc !== 8'd2 || o.rd_cyc !== 8'd0 || o.wr_seen !== 1'b0 || o.rd_we !== 1'b0)
      $display("FAIL ext_trap: got fault=%h cause=%0d bus=%h done=%0d read=%0d write=%b we=%b",
               o.trap_fault, o.trap_cause, o.trap_bus, o.done_cyc, o.rd_cyc, o.wr_seen, o.rd_we);
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore;
    res_t o, e;
    exp_q.push_back(model(enc(12'h342, 5'd9, 3'b011, 5'd4), 32'h500, 32'h00F0, 0, 5'd0, 32'd0));
    drive_op(enc(12'h342, 5'd9, 3'b011, 5'd4), 32'h500, 32'h00F0, 0, 5'd0, 32'd0, 1, 1, o);
    e = exp_q.pop_front();
    chk_cnt++;
    if (o !== e) $display("FAIL busy_ignore: got %h exp %h", o, e); else pass_cnt++;
  endtask

  task automatic test_random;
    res_t o, e;
    logic [11:0] pick [10];
    logic [11:0] sys12 [5];
    logic [31:0] r_instr, r_pc, r_rs1, r_tval;
    logic [2:0] f3;
    logic [4:0] rsf, rdf, r_cause;
    logic [11:0] f12;
    bit r_ext;
    pick  = '{12'hF11, 12'hF14, 12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h343, 12'h7C0, 12'hC00};
    sys12 = '{12'h000, 12'h001, 12'h302, 12'h105, 12'h7FF};
    for (int n = 0; n < 200; n++) begin
      f3  = 3'($urandom_range(0, 7));
      rsf = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rdf = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      f12 = pick[$urandom_range(0, 9)];
      if (f3 == 3'd0) begin
        f12 = sys12[$urandom_range(0, 4)];
        if ($urandom_range(0, 4) != 0) begin rsf = 5'd0; rdf = 5'd0; end
      end
      r_instr = enc(f12, rsf, f3, rdf);
      if ($urandom_range(0, 9) == 0) r_instr[6:0] = 7'($urandom_range(0, 127));
      r_pc    = $urandom & 32'hFFFF_FFFC;
      r_rs1   = $urandom;
      r_ext   = ($urandom_range(0, 7) == 0);
      r_cause = 5'($urandom_range(0, 31));
      r_tval  = $urandom;
      exp_q.push_back(model(r_instr, r_pc, r_rs1, r_ext, r_cause, r_tval));
      drive_op(r_instr, r_pc, r_rs1, r_ext, r_cause, r_tval, !r_ext || ($urandom_range(0, 1) == 1), 0, o);
      e = exp_q.pop_front();
      chk_cnt++;
      if (o !== e) $display("FAIL random_%0d instr=%h: got %h exp %h", n, r_instr, o, e);
      else pass_cnt++;
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    logic [11:0] impl [11];
    impl = '{12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h300, 12'h301, 12'h305,
             12'h340, 12'h341, 12'h342, 12'h343};
    for (int a = 0; a < 4096; a++) begin csr_ok[a] = 1'b0; csr_val[a] = $urandom; end
    for (int k = 0; k < 11; k++) csr_ok[impl[k]] = 1'b1;
    test_reset();
    test_csr_write();
    test_no_write();
    test_invalid_csr();
    test_ecall_mret();
    test_ext_trap();
    test_busy_ignore();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
